// File: rtl/imem_resp.sv
// rtl/imem_resp.sv - multi-cycle instruction memory responder with wait states, stall hold and flush
module imem_resp #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int WAIT  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [WIDTH-1:0] addr,
    output logic             ready,
    input  logic             flush,
    input  logic             rack,
    output logic             rvalid,
    output logic [WIDTH-1:0] rdata,
    output logic             err,
    input  logic             we,
    input  logic [WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0] wdata
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] NOP_INSN = WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] cap_addr;
    logic             accept;
    logic             load_resp;
    logic [WIDTH-1:0] rd_addr;
    logic [WIDTH-1:0] rd_widx;
    logic             rd_ok;
    logic [WIDTH-1:0] wr_widx;
    logic             wr_ok;

    logic [WIDTH-1:0] mem [DEPTH];

    // A new request can be taken when idle or when the current response is being consumed.
    assign ready  = ~flush && ((state == S_IDLE) || ((state == S_RESP) && rack));
    assign accept = req && ready;

    // Zero wait states let an accept feed the response edge directly, so read from the live address.
    assign rd_addr = accept ? addr : cap_addr;
    assign rd_widx = rd_addr >> 2;
    assign rd_ok   = (rd_addr[1:0] == 2'b00) && (rd_widx < WIDTH'(DEPTH));

    assign wr_widx = waddr >> 2;
    assign wr_ok   = wr_widx < WIDTH'(DEPTH);

    // Response registers load only on the edge that enters RESP, including RESP-to-RESP back-to-back.
    assign load_resp = (state_nx == S_RESP) && ((state != S_RESP) || accept);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: flush overrides everything, otherwise follow the accept/wait/response cycle.
    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state_nx = (WAIT == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd1) begin
                        state_nx = S_RESP;
                    end
                end
                S_RESP: begin
                    if (accept) begin
                        state_nx = (WAIT == 0) ? S_RESP : S_WAIT;
                    end else if (rack) begin
                        state_nx = S_IDLE;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Output logic: a response is presented for the whole RESP residency.
    always_comb begin
        rvalid = 1'b0;
        if (state == S_RESP) begin
            rvalid = 1'b1;
        end
    end

    // Wait-state counter: loaded on accept, counts down while waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if (flush) begin
            cnt <= 4'd0;
        end else if (accept) begin
            cnt <= 4'(WAIT);
        end else if (state == S_WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Hold the accepted address until the response is formed.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_addr <= '0;
        end else if (accept) begin
            cap_addr <= addr;
        end
    end

    // Response data/flag; the array read sees pre-write contents on a same-edge write.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
            err   <= 1'b0;
        end else if (load_resp) begin
            if (rd_ok) begin
                rdata <= mem[rd_widx[AW-1:0]];
                err   <= 1'b0;
            end else begin
                rdata <= NOP_INSN;
                err   <= 1'b1;
            end
        end
    end

    // Program-load write port; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (we && wr_ok) begin
            mem[wr_widx[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: tb/tb_imem_resp.sv
// tb/tb_imem_resp.sv - randomized and directed bench for imem_resp against a latency-based reference model
module tb_imem_resp;

    localparam int WIDTH = 32;
    localparam int DEPTH = 64;
    localparam int WAIT  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic [31:0] addr = '0;
    logic        flush = 1'b0;
    logic        rack = 1'b0;
    logic        we = 1'b0;
    logic [31:0] waddr = '0;
    logic [31:0] wdata = '0;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    always #5 clk = ~clk;

    imem_resp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WAIT(WAIT)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .addr  (addr),
        .ready (ready),
        .flush (flush),
        .rack  (rack),
        .rvalid(rvalid),
        .rdata (rdata),
        .err   (err),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: a request accepted in cycle c is visible in cycle c+WAIT+1 and held until consumed.
    logic [31:0] m_mem [DEPTH];
    bit          pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_due = 0;
    bit          m_rvalid = 1'b0;
    logic [31:0] m_rdata = '0;
    bit          m_err = 1'b0;
    bit          live = 1'b0;

    bit          obs_ready;
    bit          obs_rvalid;
    bit          obs_err;
    logic [31:0] obs_rdata;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    function automatic void model_read(input logic [31:0] a);
        if (a[1:0] != 2'b00 || (a >> 2) >= 32'(DEPTH)) begin
            m_err   = 1'b1;
            m_rdata = 32'h0000_0013;
        end else begin
            m_err   = 1'b0;
            m_rdata = m_mem[a >> 2];
        end
        m_rvalid = 1'b1;
    endfunction

    // One clock cycle: drive, compare against model at negedge, advance model across the edge.
    task automatic step(input bit i_rst, input bit i_req, input logic [31:0] i_addr, input bit i_flush,
                        input bit i_rack, input bit i_we, input logic [31:0] i_waddr, input logic [31:0] i_wdata);
        bit exp_ready;
        bit acc;
        rst = i_rst; req = i_req; addr = i_addr; flush = i_flush;
        rack = i_rack; we = i_we; waddr = i_waddr; wdata = i_wdata;
        @(negedge clk);
        obs_ready = ready; obs_rvalid = rvalid; obs_rdata = rdata; obs_err = err;
        exp_ready = !i_flush && ((!pend && !m_rvalid) || (m_rvalid && i_rack));
        if (live) begin
            chk("ready", {31'd0, obs_ready}, {31'd0, exp_ready});
            chk("rvalid", {31'd0, obs_rvalid}, {31'd0, m_rvalid});
            chk("rdata", obs_rdata, m_rdata);
            chk("err", {31'd0, obs_err}, {31'd0, m_err});
        end
        acc = i_req && exp_ready;
        if (i_rst) begin
            pend = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_err = 1'b0; live = 1'b1;
        end else if (i_flush) begin
            pend = 1'b0; m_rvalid = 1'b0;
        end else begin
            if (m_rvalid && i_rack) m_rvalid = 1'b0;
            if (pend && (cyc + 1 == pend_due)) begin
                model_read(pend_addr);
                pend = 1'b0;
            end
            if (acc) begin
                if (WAIT == 0) begin
                    model_read(i_addr);
                end else begin
                    pend = 1'b1; pend_addr = i_addr; pend_due = cyc + 1 + WAIT;
                end
            end
        end
        if (i_we && (i_waddr >> 2) < 32'(DEPTH)) m_mem[i_waddr >> 2] = i_wdata;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rk);
        step(1'b0, 1'b0, 32'h0, 1'b0, rk, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic rd(input logic [31:0] a, input bit rk);
        step(1'b0, 1'b1, a, 1'b0, rk, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, a, d);
    endtask

    // Step until a response is seen; n returns the number of cycles taken (bounded).
    task automatic run_until_rv(input bit rk, output int n);
        n = 0;
        do begin
            idle(rk);
            n++;
        end while (!obs_rvalid && n < 12);
        if (!obs_rvalid) chk("rvalid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int          n;
        int          nr;
        int          acc_idx;
        int          rv_cyc [3];
        logic [31:0] rv_dat [3];
        logic [31:0] exp_dat [3];
        logic [31:0] b2b_addr [3];
        logic [31:0] err_addr [3];
        logic [31:0] a;
        bit          rq;

        #1;
        // 1. reset with a request pending on the inputs
        step(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("rst_rvalid", {31'd0, obs_rvalid}, 32'd0);
        chk("rst_rdata", obs_rdata, 32'h0);
        idle(1'b1);
        chk("ready_after_rst", {31'd0, obs_ready}, 32'd1);

        for (int i = 0; i < DEPTH; i++) wr(32'(i * 4), $urandom);
        wr(32'h0, 32'h0050_0113);
        wr(32'h20, 32'h00A0_0193);

        // 2. basic read, rack held high
        rd(32'h0, 1'b1);
        chk("basic_accept", {31'd0, obs_ready}, 32'd1);
        run_until_rv(1'b1, n);
        chk("basic_latency", 32'(n), 32'd3);
        chk("basic_rdata", obs_rdata, 32'h0050_0113);
        chk("basic_err", {31'd0, obs_err}, 32'd0);
        idle(1'b1);
        chk("basic_idle", {31'd0, obs_rvalid}, 32'd0);

        // 3. stall hold
        rd(32'h20, 1'b0);
        run_until_rv(1'b0, n);
        repeat (3) begin
            rd(32'h4, 1'b0);
            chk("stall_rvalid", {31'd0, obs_rvalid}, 32'd1);
            chk("stall_rdata", obs_rdata, 32'h00A0_0193);
            chk("stall_ready", {31'd0, obs_ready}, 32'd0);
        end
        idle(1'b1);
        idle(1'b1);
        chk("stall_release", {31'd0, obs_rvalid}, 32'd0);

        // 4. flush, then reset, one cycle after accepting 0x4
        for (int k = 0; k < 2; k++) begin
            rd(32'h4, 1'b1);
            if (k == 0) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
            else        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
            repeat (4) begin
                idle(1'b1);
                chk("cancel_no_rvalid", {31'd0, obs_rvalid}, 32'd0);
            end
            rd(32'h20, 1'b1);
            run_until_rv(1'b1, n);
            chk("cancel_next_rdata", obs_rdata, 32'h00A0_0193);
        end

        // 5. misaligned and out-of-range addresses
        err_addr[0] = 32'h2; err_addr[1] = 32'h100; err_addr[2] = 32'hFFFF_FFFC;
        for (int k = 0; k < 3; k++) begin
            rd(err_addr[k], 1'b1);
            run_until_rv(1'b1, n);
            chk("err_flag", {31'd0, obs_err}, 32'd1);
            chk("err_nop", obs_rdata, 32'h0000_0013);
        end

        // 6a. back-to-back reads
        b2b_addr[0] = 32'h0; b2b_addr[1] = 32'h4; b2b_addr[2] = 32'h8;
        for (int k = 0; k < 3; k++) exp_dat[k] = m_mem[k];
        idle(1'b1);
        rd(b2b_addr[0], 1'b1);
        acc_idx = 1;
        nr = 0;
        for (int t = 0; t < 20 && nr < 3; t++) begin
            rq = (acc_idx < 3);
            a  = rq ? b2b_addr[acc_idx] : 32'h0;
            step(1'b0, rq, a, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
            if (rq && obs_ready) acc_idx++;
            if (obs_rvalid) begin
                rv_cyc[nr] = cyc;
                rv_dat[nr] = obs_rdata;
                nr++;
            end
        end
        chk("b2b_count", 32'(nr), 32'd3);
        for (int k = 0; k < nr; k++) chk("b2b_data", rv_dat[k], exp_dat[k]);
        for (int k = 1; k < nr; k++) chk("b2b_gap", 32'(rv_cyc[k] - rv_cyc[k-1]), 32'd3);

        // 6b. write to the word being read on the RESP-entry edge
        idle(1'b1);
        rd(32'h0, 1'b1);
        idle(1'b1);
        wr(32'h0, 32'hDEAD_BEEF);
        idle(1'b1);
        chk("collide_rvalid", {31'd0, obs_rvalid}, 32'd1);
        chk("collide_old", obs_rdata, 32'h0050_0113);
        rd(32'h0, 1'b1);
        run_until_rv(1'b1, n);
        chk("collide_new", obs_rdata, 32'hDEAD_BEEF);

        // Randomized traffic checked cycle by cycle against the model.
        for (int t = 0; t < 3000; t++) begin
            bit          r_rst;
            bit          r_we;
            logic [31:0] r_addr;
            r_rst = ($urandom_range(0, 199) == 0);
            r_we  = !r_rst && ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 9))
                0:       r_addr = $urandom;
                1:       r_addr = 32'($urandom_range(0, 300));
                default: r_addr = 32'($urandom_range(0, DEPTH - 1) * 4);
            endcase
            step(r_rst, ($urandom_range(0, 9) < 6), r_addr, ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) < 6), r_we, 32'($urandom_range(0, DEPTH + 3) * 4), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
